// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma stream controller slice.
package enigma_pkg;

  localparam int CHAR_WIDTH    = 8;
  localparam int POS_WIDTH     = 5;
  localparam int ALPHABET_SIZE = 26;

  localparam logic [CHAR_WIDTH-1:0] ASCII_UPPER_A = 8'h41;
  localparam logic [CHAR_WIDTH-1:0] ASCII_UPPER_Z = 8'h5A;
  localparam logic [CHAR_WIDTH-1:0] ASCII_LOWER_A = 8'h61;
  localparam logic [CHAR_WIDTH-1:0] ASCII_LOWER_Z = 8'h7A;
  // Distance between a lowercase letter and its uppercase form.
  localparam logic [CHAR_WIDTH-1:0] ASCII_CASE_OFFSET = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ACCEPT = 3'd2,
    ST_STEP   = 3'd3,
    ST_ENCODE = 3'd4,
    ST_EMIT   = 3'd5,
    ST_FINISH = 3'd6
  } state_e;

  // A 5-bit position spans 0..31, so one conditional subtract brings it into 0..25.
  function automatic logic [POS_WIDTH-1:0] pos_mod_alphabet(input logic [POS_WIDTH-1:0] pos);
    if (pos >= POS_WIDTH'(ALPHABET_SIZE)) begin
      return pos - POS_WIDTH'(ALPHABET_SIZE);
    end
    return pos;
  endfunction

endpackage

// File: rtl/enigma_stream_controller_char_classifier.sv
// Combinational character classifier: flags letters and folds lowercase to uppercase.
module char_classifier
  import enigma_pkg::*;
(
  input  logic [CHAR_WIDTH-1:0] char_i,
  output logic                  is_letter_o,
  output logic [CHAR_WIDTH-1:0] upper_o
);

  logic is_upper;
  logic is_lower;

  // Range-compare against the ASCII letter bands; non-letters pass through unchanged.
  always_comb begin
    is_upper    = (char_i >= ASCII_UPPER_A) && (char_i <= ASCII_UPPER_Z);
    is_lower    = (char_i >= ASCII_LOWER_A) && (char_i <= ASCII_LOWER_Z);
    is_letter_o = is_upper || is_lower;
    upper_o     = is_lower ? (char_i - ASCII_CASE_OFFSET) : char_i;
  end

endmodule

// File: rtl/enigma_stream_controller.sv
// Session controller that feeds a plaintext byte stream through an external
// Enigma core and returns the ciphertext stream with valid/ready handshakes.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; zero-length start only pulses done
// LOAD   | one-cycle coreLoad with the latched rotor start positions
// ACCEPT | inReady high, waiting for the next plaintext byte
// STEP   | one-cycle coreStep so rotors advance before encoding
// ENCODE | capture the core's combinational output into outChar
// EMIT   | outValid high until the consumer takes the byte
// FINISH | one-cycle done, then back to IDLE
module enigma_stream_controller
  import enigma_pkg::*;
#(
  parameter int LEN_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [POS_WIDTH-1:0]  startPosition1_i,
  input  logic [POS_WIDTH-1:0]  startPosition2_i,
  input  logic [POS_WIDTH-1:0]  startPosition3_i,
  input  logic [LEN_WIDTH-1:0]  msgLength_i,
  input  logic [CHAR_WIDTH-1:0] inChar_i,
  input  logic                  inValid_i,
  output logic                  inReady_o,
  output logic [CHAR_WIDTH-1:0] outChar_o,
  output logic                  outValid_o,
  input  logic                  outReady_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  charCount_o,
  output logic [CHAR_WIDTH-1:0] coreChar_o,
  output logic [POS_WIDTH-1:0]  coreStartPosition1_o,
  output logic [POS_WIDTH-1:0]  coreStartPosition2_o,
  output logic [POS_WIDTH-1:0]  coreStartPosition3_o,
  output logic                  coreLoad_o,
  output logic                  coreStep_o,
  input  logic [CHAR_WIDTH-1:0] coreOutChar_i
);

  state_e                state_q, state_d;
  logic [POS_WIDTH-1:0]  pos1_q, pos1_d;
  logic [POS_WIDTH-1:0]  pos2_q, pos2_d;
  logic [POS_WIDTH-1:0]  pos3_q, pos3_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic [CHAR_WIDTH-1:0] core_char_q, core_char_d;
  logic [CHAR_WIDTH-1:0] out_char_q, out_char_d;
  logic                  zero_done_q, zero_done_d;

  logic                  in_is_letter;
  logic [CHAR_WIDTH-1:0] in_upper;
  logic [LEN_WIDTH-1:0]  count_inc;
  logic                  start_session;
  logic                  start_empty;
  logic                  abort_active;

  char_classifier u_classifier (
    .char_i      (inChar_i),
    .is_letter_o (in_is_letter),
    .upper_o     (in_upper)
  );

  assign count_inc     = count_q + LEN_WIDTH'(1);
  assign start_session = (state_q == ST_IDLE) && start_i && (msgLength_i != '0);
  assign start_empty   = (state_q == ST_IDLE) && start_i && (msgLength_i == '0);
  // Abort only has meaning inside a session; in IDLE it is ignored.
  assign abort_active  = abort_i && (state_q != ST_IDLE);

  // State register; reset dominates everything else.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition including the EMIT handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_session) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_ACCEPT;
      ST_ACCEPT: if (inValid_i) state_d = in_is_letter ? ST_STEP : ST_EMIT;
      ST_STEP:   state_d = ST_ENCODE;
      ST_ENCODE: state_d = ST_EMIT;
      ST_EMIT: begin
        if (outReady_i) begin
          state_d = (count_inc == len_q) ? ST_FINISH : ST_ACCEPT;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort_active) begin
      state_d = ST_IDLE;
    end
  end

  // Moore-style outputs decoded from the current state; done is masked by abort.
  always_comb begin
    busy_o     = (state_q != ST_IDLE);
    inReady_o  = (state_q == ST_ACCEPT);
    outValid_o = (state_q == ST_EMIT);
    coreLoad_o = (state_q == ST_LOAD);
    coreStep_o = (state_q == ST_STEP);
    done_o     = ((state_q == ST_FINISH) && !abort_i) || zero_done_q;
  end

  // Datapath next values: session latches, character capture and the emitted-count.
  always_comb begin
    pos1_d      = pos1_q;
    pos2_d      = pos2_q;
    pos3_d      = pos3_q;
    len_d       = len_q;
    count_d     = count_q;
    core_char_d = core_char_q;
    out_char_d  = out_char_q;
    zero_done_d = start_empty;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          count_d = '0;
        end
        if (start_session) begin
          pos1_d = pos_mod_alphabet(startPosition1_i);
          pos2_d = pos_mod_alphabet(startPosition2_i);
          pos3_d = pos_mod_alphabet(startPosition3_i);
          len_d  = msgLength_i;
        end
      end
      ST_ACCEPT: begin
        if (inValid_i && !abort_i) begin
          core_char_d = in_upper;
          // Non-letters bypass the core entirely and go straight out raw.
          if (!in_is_letter) begin
            out_char_d = inChar_i;
          end
        end
      end
      ST_ENCODE: begin
        if (!abort_i) begin
          out_char_d = coreOutChar_i;
        end
      end
      ST_EMIT: begin
        if (outReady_i && !abort_i) begin
          count_d = count_inc;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pos1_q      <= '0;
      pos2_q      <= '0;
      pos3_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      core_char_q <= '0;
      out_char_q  <= '0;
      zero_done_q <= 1'b0;
    end else begin
      pos1_q      <= pos1_d;
      pos2_q      <= pos2_d;
      pos3_q      <= pos3_d;
      len_q       <= len_d;
      count_q     <= count_d;
      core_char_q <= core_char_d;
      out_char_q  <= out_char_d;
      zero_done_q <= zero_done_d;
    end
  end

  assign outChar_o            = out_char_q;
  assign charCount_o          = count_q;
  assign coreChar_o           = core_char_q;
  assign coreStartPosition1_o = pos1_q;
  assign coreStartPosition2_o = pos2_q;
  assign coreStartPosition3_o = pos3_q;

endmodule

// File: tb/tb_enigma_stream_controller.sv
// Directed bench for the Enigma stream controller with a Caesar-shift core model.
module tb_enigma_stream_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [4:0] sp1, sp2, sp3;
  logic [7:0] msg_len;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [7:0] char_count;
  logic [7:0] core_char;
  logic [4:0] core_sp1, core_sp2, core_sp3;
  logic       core_load;
  logic       core_step;
  logic [7:0] core_out;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int load_cnt = 0;
  int done_cnt = 0;
  int model_steps = 0;
  int model_base = 0;

  enigma_stream_controller #(.LEN_WIDTH(8)) dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .start_i              (start),
    .abort_i              (abort),
    .startPosition1_i     (sp1),
    .startPosition2_i     (sp2),
    .startPosition3_i     (sp3),
    .msgLength_i          (msg_len),
    .inChar_i             (in_char),
    .inValid_i            (in_valid),
    .inReady_o            (in_ready),
    .outChar_o            (out_char),
    .outValid_o           (out_valid),
    .outReady_i           (out_ready),
    .busy_o               (busy),
    .done_o               (done),
    .charCount_o          (char_count),
    .coreChar_o           (core_char),
    .coreStartPosition1_o (core_sp1),
    .coreStartPosition2_o (core_sp2),
    .coreStartPosition3_o (core_sp3),
    .coreLoad_o           (core_load),
    .coreStep_o           (core_step),
    .coreOutChar_i        (core_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] caesar(input logic [7:0] c, input int shift);
    int v;
    if (c >= 8'h41 && c <= 8'h5A) begin
      v = (int'(c) - 65 + shift) % 26;
      return 8'(65 + v);
    end
    return c;
  endfunction

  assign core_out = caesar(core_char, model_base + model_steps);

  always @(posedge clk) begin
    if (reset) begin
      model_steps <= 0;
      model_base  <= 0;
    end else if (core_load) begin
      model_steps <= 0;
      model_base  <= int'(core_sp1);
    end else if (core_step) begin
      model_steps <= model_steps + 1;
    end
    if (core_step) step_cnt <= step_cnt + 1;
    if (core_load) load_cnt <= load_cnt + 1;
    if (done)      done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3,
                          input logic [7:0] len, input logic [4:0] e1, input string tag);
    sp1 = p1; sp2 = p2; sp3 = p3; msg_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_load"}, 32'(core_load), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_pos1"}, 32'(core_sp1), 32'(e1));
  endtask

  task automatic send_char(input logic [7:0] c, input logic [7:0] exp_c, input int exp_lat,
                           input string tag);
    int k;
    int n;
    in_char = c; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_inready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_char = 8'h00;
    n = 1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_outchar"}, 32'(out_char), 32'(exp_c));
    chk({tag, "_no_overlap"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, d0, l0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    sp1 = 5'd0; sp2 = 5'd0; sp3 = 5'd0; msg_len = 8'd0;
    in_char = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_inready", 32'(in_ready), 32'd0);
    chk("rst_outvalid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(char_count), 32'd0);
    chk("rst_outchar", 32'(out_char), 32'd0);
    chk("rst_corechar", 32'(core_char), 32'd0);
    chk("rst_load_step", 32'({core_load, core_step}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Session 1: "ABC" from 0/0/0 -> "BDF".
    s0 = step_cnt; d0 = done_cnt;
    do_start(5'd0, 5'd0, 5'd0, 8'd3, 5'd0, "s1");
    send_char(8'h41, 8'h42, 3, "s1_A");
    send_char(8'h42, 8'h44, 3, "s1_B");
    send_char(8'h43, 8'h46, 3, "s1_C");
    @(negedge clk);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_finish_busy", 32'(busy), 32'd1);
    chk("s1_count", 32'(char_count), 32'd3);
    @(negedge clk);
    chk("s1_done_drop", 32'(done), 32'd0);
    chk("s1_idle_busy", 32'(busy), 32'd0);
    chk("s1_count_hold", 32'(char_count), 32'd3);
    chk("s1_steps", 32'(step_cnt - s0), 32'd3);
    chk("s1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Session 2: "A b" from 28/27/25 (reduced to 2/1/25) -> "D F".
    s0 = step_cnt;
    do_start(5'd28, 5'd27, 5'd25, 8'd3, 5'd2, "s2");
    chk("s2_pos2", 32'(core_sp2), 32'd1);
    chk("s2_pos3", 32'(core_sp3), 32'd25);
    send_char(8'h41, 8'h44, 3, "s2_A");
    send_char(8'h20, 8'h20, 1, "s2_space");
    chk("s2_space_corechar", 32'(core_char), 32'h20);
    send_char(8'h62, 8'h46, 3, "s2_b");
    chk("s2_fold", 32'(core_char), 32'h42);
    chk("s2_steps", 32'(step_cnt - s0), 32'd2);
    @(negedge clk);
    chk("s2_done", 32'(done), 32'd1);
    @(negedge clk);

    // Session 3: consumer stalls EMIT for 5 cycles.
    do_start(5'd0, 5'd0, 5'd0, 8'd1, 5'd0, "s3");
    out_ready = 1'b0;
    send_char(8'h43, 8'h44, 3, "s3_C");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s3_stall_valid", 32'(out_valid), 32'd1);
      chk("s3_stall_char", 32'(out_char), 32'h44);
      chk("s3_stall_inready", 32'(in_ready), 32'd0);
      chk("s3_stall_count", 32'(char_count), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("s3_done", 32'(done), 32'd1);
    chk("s3_count", 32'(char_count), 32'd1);
    @(negedge clk);

    // Session 4: abort collides with the second output handshake.
    d0 = done_cnt;
    do_start(5'd0, 5'd0, 5'd0, 8'd3, 5'd0, "s4");
    send_char(8'h41, 8'h42, 3, "s4_A");
    send_char(8'h42, 8'h44, 3, "s4_B");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("s4_abort_busy", 32'(busy), 32'd0);
    chk("s4_abort_outvalid", 32'(out_valid), 32'd0);
    chk("s4_abort_count", 32'(char_count), 32'd1);
    repeat (3) @(negedge clk);
    chk("s4_no_done", 32'(done_cnt - d0), 32'd0);

    // Session 5: reset during STEP, then a zero-length start.
    do_start(5'd5, 5'd0, 5'd0, 8'd2, 5'd5, "s5");
    in_char = 8'h41; in_valid = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("s5_in_step", 32'(core_step), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("s5_rst_status", 32'({busy, done, in_ready, out_valid, core_load, core_step}), 32'd0);
    chk("s5_rst_chars", 32'({out_char, core_char, char_count}), 32'd0);
    chk("s5_rst_pos1", 32'(core_sp1), 32'd0);
    l0 = load_cnt;
    sp1 = 5'd7; msg_len = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s5_zero_done", 32'(done), 32'd1);
    chk("s5_zero_busy", 32'(busy), 32'd0);
    chk("s5_zero_pos1", 32'(core_sp1), 32'd0);
    @(negedge clk);
    chk("s5_zero_done_drop", 32'(done), 32'd0);
    chk("s5_zero_no_load", 32'(load_cnt - l0), 32'd0);
    chk("s5_zero_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enigma_stream_controller.md
ENIGMA_STREAM_CONTROLLER -- requirements
Module: enigma_stream_controller

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 8, width of message-length and character-count fields.
REQ-002 SHALL have clock  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have start  input  1  begin session; sampled only in IDLE.
REQ-005 SHALL have abort  input  1  terminate session from any non-IDLE state.
REQ-006 SHALL have startPosition1/2/3  input  5 each  rotor start positions latched at start.
REQ-007 SHALL have msgLength  input  LEN_WIDTH  characters in session, latched at start.
REQ-008 SHALL have inChar/inValid/inReady  input 8/input 1/output 1  plaintext stream, valid/ready handshake.
REQ-009 SHALL have outChar/outValid/outReady  output 8/output 1/input 1  ciphertext stream, valid/ready handshake.
REQ-010 SHALL have busy  output 1, done  output 1, charCount  output LEN_WIDTH  status.
REQ-011 SHALL have coreChar  output 8, coreStartPosition1/2/3  output 5, coreLoad  output 1, coreStep  output 1, coreOutChar  input 8  external Enigma core port; core output combinational from coreChar and current rotor state.

Function
REQ-012 SHALL implement states IDLE, LOAD, ACCEPT, STEP, ENCODE, EMIT, FINISH.
REQ-013 IDLE: busy=0, inReady=0; start=1 and msgLength!=0 -> latch positions (each reduced modulo 26) and length, clear charCount, go LOAD.
REQ-014 IDLE with start=1 and msgLength=0 SHALL pulse done for one cycle next cycle and remain IDLE.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 LOAD: coreLoad=1 for exactly one cycle with latched positions on coreStartPosition1/2/3; next ACCEPT.
REQ-017 ACCEPT: inReady=1; on inValid&inReady the character SHALL be registered into coreChar, lowercase a-z folded to uppercase.
REQ-018 Accepted letter (A-Z after folding) -> STEP; any other byte -> EMIT with outChar equal to the raw byte, rotors not stepped.
REQ-019 STEP: coreStep=1 for exactly one cycle (rotors advance before encoding); next ENCODE.
REQ-020 ENCODE: coreOutChar SHALL be registered into outChar; next EMIT.
REQ-021 Latency: letter outValid rises 3 cycles after accepting edge; passthrough byte 1 cycle after.
REQ-022 EMIT: outValid=1, outChar stable until outValid&outReady; on handshake charCount increments by 1.
REQ-023 After EMIT handshake: charCount reaching latched length -> FINISH, else -> ACCEPT.
REQ-024 FINISH: done=1 for exactly one cycle, busy=1; next IDLE; charCount holds final value until next start.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE next cycle, drop pending output, suppress done, not increment charCount; abort wins over a simultaneous output handshake.
REQ-026 busy SHALL be 1 in every state except IDLE; inReady and outValid SHALL never be 1 in the same cycle.
REQ-027 coreLoad and coreStep SHALL never be asserted in the same cycle.

Reset
REQ-028 reset SHALL force IDLE and zero outChar, coreChar, charCount, coreStartPosition1/2/3, latched length; outValid, inReady, coreLoad, coreStep, busy, done = 0.
REQ-029 reset SHALL take priority over start, abort and all handshakes, including mid-session.

Structure
REQ-030 Shared package enigma_pkg SHALL hold the state enumeration, CHAR_WIDTH=8, POS_WIDTH=5, ALPHABET_SIZE=26, ASCII constants for "A","Z","a","z".
REQ-031 SHALL contain one sub-module char_classifier (combinational: isLetter flag, uppercase fold).
REQ-032 The Enigma core SHALL be instantiated outside this block.

Verification
REQ-033 Bench core model: coreOutChar = coreChar Caesar-shifted by number of coreStep pulses since coreLoad plus startPosition1.
REQ-034 start, positions 0/0/0, msgLength=3, input "ABC", outReady=1 -> outputs "B","D","F", coreStep pulsed 3 times, done one cycle, charCount=3.
REQ-035 msgLength=3, input "A b" (space middle), positions 2/0/0 -> "D"," ","F"; coreStep pulsed exactly 2 times; lowercase b folded.
REQ-036 outReady held 0 for 5 cycles during EMIT -> outValid and outChar stable, inReady=0, charCount unchanged.
REQ-037 abort asserted in same cycle as second output handshake -> IDLE next cycle, done never asserted, charCount=1.
REQ-038 reset asserted in STEP, and start with msgLength=0 in IDLE -> all outputs zero next cycle; zero-length start gives one-cycle done with no coreLoad.
